// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes plus ALUOp and forward-select encodings
package alu_pkg;
   localparam logic [3:0] OP_AND     = 4'b0000;
   localparam logic [3:0] OP_XOR     = 4'b0001;
   localparam logic [3:0] OP_ADD     = 4'b0010;
   localparam logic [3:0] OP_SLLI    = 4'b0110;
   localparam logic [3:0] OP_SRAI    = 4'b0111;
   localparam logic [3:0] OP_EQUAL   = 4'b1000;
   localparam logic [3:0] OP_SLT     = 4'b1100;
   localparam logic [3:0] OP_ILLEGAL = 4'b1111;
   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,
      ALUOP_BRANCH = 2'b01,
      ALUOP_ARITH  = 2'b10,
      ALUOP_RSVD   = 2'b11
   } aluop_e;
   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_RF2 = 2'b11
   } fwd_e;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational ALUOp/Funct3/Funct7 to ALU operation code
//   aluop_i, funct3_i, funct7_i : instruction control fields
//   op_o                        : 4-bit ALU operation code (1111 when illegal)
//   illegal_o                   : combination not supported by the ALU
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [1:0] aluop_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [3:0] op_o,
   output logic       illegal_o
);
   always_comb begin
      op_o = OP_ILLEGAL;
      case (aluop_e'(aluop_i))
         ALUOP_MEM:    op_o = OP_ADD;
         ALUOP_BRANCH: op_o = OP_EQUAL;
         ALUOP_ARITH:
            case (funct3_i)
               3'b000:  op_o = funct7_i == 7'b0000000 ? OP_ADD : OP_ILLEGAL;
               3'b111:  op_o = OP_AND;
               3'b100:  op_o = OP_XOR;
               3'b010:  op_o = OP_SLT;
               3'b001:  op_o = funct7_i == 7'b0000000 ? OP_SLLI : OP_ILLEGAL;
               3'b101:  op_o = funct7_i == 7'b0100000 ? OP_SRAI : OP_ILLEGAL;
               default: op_o = OP_ILLEGAL;
            endcase
         default:      op_o = OP_ILLEGAL;
      endcase
      illegal_o = op_o == OP_ILLEGAL;
   end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX boundary producing registered ALU operation and operands
//   clk, reset            : clock, synchronous active-high reset
//   stall, flush          : hold all outputs / insert a bubble (flush wins)
//   in_valid              : decode-stage instruction valid
//   ALUOp, Funct3, Funct7 : operation decode inputs
//   ALUSrc, ImmG          : immediate select and value for operand B
//   RD1, RD2              : register-file read data
//   ForwardA, ForwardB    : operand source selects (WBData / MEMData / register)
//   out_valid, Operation, SrcA, SrcB, illegal : registered issue outputs
//   illegal_cnt           : saturating count of valid illegal ops issued
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [1:0]               ALUOp,
   input  logic [2:0]               Funct3,
   input  logic [6:0]               Funct7,
   input  logic                     ALUSrc,
   input  logic [DATA_WIDTH-1:0]    RD1,
   input  logic [DATA_WIDTH-1:0]    RD2,
   input  logic [DATA_WIDTH-1:0]    ImmG,
   input  logic [1:0]               ForwardA,
   input  logic [1:0]               ForwardB,
   input  logic [DATA_WIDTH-1:0]    WBData,
   input  logic [DATA_WIDTH-1:0]    MEMData,
   output logic                     out_valid,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic                     illegal,
   output logic [CNT_WIDTH-1:0]     illegal_cnt
);
   logic [3:0]               dec_op;
   logic                     dec_ill;
   logic [DATA_WIDTH-1:0]    b_fwd, b_sel;
   logic                     valid_q, ill_q;
   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic [DATA_WIDTH-1:0]    a_q, a_d, b_q, b_d;
   logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;

   alu_op_decode u_dec (
      .aluop_i   (ALUOp),
      .funct3_i  (Funct3),
      .funct7_i  (Funct7),
      .op_o      (dec_op),
      .illegal_o (dec_ill)
   );

   always_comb begin
      a_d   = ForwardA == FWD_WB ? WBData : ForwardA == FWD_MEM ? MEMData : RD1;
      b_fwd = ForwardB == FWD_WB ? WBData : ForwardB == FWD_MEM ? MEMData : RD2;
      b_sel = ALUSrc ? ImmG : b_fwd;
      // shifts use only the 5-bit shift amount, regardless of operand source
      b_d   = (dec_op == OP_SLLI || dec_op == OP_SRAI) ? {{(DATA_WIDTH-5){1'b0}}, b_sel[4:0]} : b_sel;
      op_d  = OPCODE_LENGTH'(dec_op);
      cnt_d = (in_valid && dec_ill && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ill_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ill_q   <= 1'b0;
      end else if (!stall) begin
         valid_q <= in_valid;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ill_q   <= dec_ill;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid   = valid_q;
   assign Operation   = op_q;
   assign SrcA        = a_q;
   assign SrcB        = b_q;
   assign illegal     = ill_q;
   assign illegal_cnt = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: random and directed checks of alu_issue_stage against a reference model
module tb_alu_issue_stage;
   logic        clk = 1'b0;
   logic        reset, stall, flush, in_valid, ALUSrc;
   logic [1:0]  ALUOp, ForwardA, ForwardB;
   logic [2:0]  Funct3;
   logic [6:0]  Funct7;
   logic [31:0] RD1, RD2, ImmG, WBData, MEMData;
   logic        out_valid, illegal;
   logic [3:0]  Operation;
   logic [31:0] SrcA, SrcB;
   logic [15:0] illegal_cnt;

   int n_checks = 0;
   int n_errors = 0;

   logic        m_valid, m_ill;
   logic [3:0]  m_op;
   logic [31:0] m_a, m_b;
   int          m_cnt;

   alu_issue_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
      .ALUOp(ALUOp), .Funct3(Funct3), .Funct7(Funct7), .ALUSrc(ALUSrc),
      .RD1(RD1), .RD2(RD2), .ImmG(ImmG), .ForwardA(ForwardA), .ForwardB(ForwardB),
      .WBData(WBData), .MEMData(MEMData), .out_valid(out_valid), .Operation(Operation),
      .SrcA(SrcA), .SrcB(SrcB), .illegal(illegal), .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {illegal, operation} from the instruction-field table
   function automatic logic [4:0] ref_decode(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7);
      if (aop == 2'd0) return 5'h02;
      if (aop == 2'd1) return 5'h08;
      if (aop == 2'd2) begin
         if (f3 == 3'd7) return 5'h00;
         if (f3 == 3'd4) return 5'h01;
         if (f3 == 3'd2) return 5'h0C;
         if (f3 == 3'd0 && f7 == 7'd0) return 5'h02;
         if (f3 == 3'd1 && f7 == 7'd0) return 5'h06;
         if (f3 == 3'd5 && f7 == 7'h20) return 5'h07;
      end
      return 5'h1F;
   endfunction

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
      return sel == 2'd1 ? WBData : sel == 2'd2 ? MEMData : rf;
   endfunction

   task automatic model_edge();
      logic [4:0]  d;
      logic [31:0] b;
      d = ref_decode(ALUOp, Funct3, Funct7);
      b = ALUSrc ? ImmG : pick(ForwardB, RD2);
      if (d[3:0] == 4'd6 || d[3:0] == 4'd7) b = b % 32;
      if (reset) begin
         {m_valid, m_ill, m_op, m_a, m_b} = '0;
         m_cnt = 0;
      end else if (flush) begin
         {m_valid, m_ill, m_op, m_a, m_b} = '0;
      end else if (!stall) begin
         m_valid = in_valid;
         m_op    = d[3:0];
         m_ill   = d[4];
         m_a     = pick(ForwardA, RD1);
         m_b     = b;
         if (in_valid && d[4] && m_cnt < 65535) m_cnt++;
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".op"}, 32'(Operation), 32'(m_op));
      check({tag, ".a"}, SrcA, m_a);
      check({tag, ".b"}, SrcB, m_b);
      check({tag, ".ill"}, 32'(illegal), 32'(m_ill));
      check({tag, ".cnt"}, 32'(illegal_cnt), 32'(m_cnt));
   endtask

   task automatic rand_inputs();
      in_valid = 1'($urandom);
      ALUOp    = 2'($urandom);
      Funct3   = 3'($urandom);
      case ($urandom % 3)
         0:       Funct7 = 7'h00;
         1:       Funct7 = 7'h20;
         default: Funct7 = 7'($urandom);
      endcase
      ALUSrc   = 1'($urandom);
      ForwardA = 2'($urandom);
      ForwardB = 2'($urandom);
      RD1 = $urandom; RD2 = $urandom; ImmG = $urandom;
      WBData = $urandom; MEMData = $urandom;
   endtask

   task automatic set_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7);
      ALUOp = aop; Funct3 = f3; Funct7 = f7;
   endtask

   initial begin
      {m_valid, m_ill, m_op, m_a, m_b} = '0;
      m_cnt = 0;
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      rand_inputs();
      cycle();
      check_all("rst0");
      rand_inputs();
      cycle();
      check_all("rst1");
      check("rst_cnt", 32'(illegal_cnt), 32'd0);
      reset = 1'b0;

      // R-type ADD with forwarding from WB and MEM
      in_valid = 1'b1; set_op(2'b10, 3'b000, 7'h00);
      ForwardA = 2'b01; WBData = 32'd5; ForwardB = 2'b10; MEMData = 32'd7; ALUSrc = 1'b0;
      cycle();
      check_all("radd");
      check("radd_op", 32'(Operation), 32'h2);
      check("radd_a", SrcA, 32'd5);
      check("radd_b", SrcB, 32'd7);

      // SRAI masks the immediate to its low five bits
      set_op(2'b10, 3'b101, 7'h20); ALUSrc = 1'b1; ImmG = 32'hFFFF_FFE3;
      ForwardA = 2'b00; RD1 = 32'h8000_0000;
      cycle();
      check_all("srai");
      check("srai_op", 32'(Operation), 32'h7);
      check("srai_b", SrcB, 32'h3);
      check("srai_a", SrcA, 32'h8000_0000);

      // stall holds, stall+flush bubbles
      set_op(2'b10, 3'b000, 7'h00); ALUSrc = 1'b0; ForwardA = 2'b01; ForwardB = 2'b10;
      cycle();
      check_all("cap");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         cycle();
         check_all("stall");
         check("stall_a", SrcA, 32'd5);
      end
      flush = 1'b1;
      cycle();
      check_all("sflush");
      check("sflush_valid", 32'(out_valid), 32'd0);
      check("sflush_op", 32'(Operation), 32'd0);
      stall = 1'b0; flush = 1'b0;

      // illegal counting with one stalled edge in between
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      in_valid = 1'b1; set_op(2'b10, 3'b000, 7'h20);
      cycle(); cycle();
      stall = 1'b1;
      cycle();
      stall = 1'b0;
      cycle(); cycle();
      check_all("ill");
      check("ill_flag", 32'(illegal), 32'd1);
      check("ill_op", 32'(Operation), 32'hF);
      check("ill_cnt", 32'(illegal_cnt), 32'd4);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rand_inputs();
         reset = ($urandom % 50) == 0;
         flush = ($urandom % 10) == 0;
         stall = ($urandom % 5) == 0;
         cycle();
         check_all("rand");
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;

      // counter saturation
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      in_valid = 1'b1; set_op(2'b11, 3'b000, 7'h00);
      for (int i = 0; i < 65534; i++) cycle();
      check("sat_pre", 32'(illegal_cnt), 32'hFFFE);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check_all("sat");
         check("sat_cnt", 32'(illegal_cnt), 32'hFFFF);
      end
      in_valid = 1'b0;
      cycle();
      check_all("sat_nv");
      check("sat_nv_cnt", 32'(illegal_cnt), 32'hFFFF);
      check("sat_nv_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
